mult_div_unit: RTL and testbench

Iterative 32×32 multiply/divide unit with HI/LO result registers for the CPU datapath. It consumes the two register-file read ports as operands (srcA = rs, srcB = rt) and executes MULT/MULTU/DIV/DIVU over multiple cycles under a start/busy/done handshake. The write-back mux reads its hi/lo outputs for MFHI/MFLO, which return results to the register file. MTHI/MTLO load the HI/LO registers directly.

---
 rtl/mult_div_unit_if.sv | 27 ++
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the CPU datapath and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] writeData;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB, hiWrite, loWrite, writeData,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, hiWrite, loWrite, writeData,
        output busy, done, divByZero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on unsigned magnitudes; the sign fix-up happens on the final write.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);
    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t               state;
    logic [5:0]           cnt;
    logic [1:0]           op_q;
    logic                 sign_a;
    logic                 sign_b;
    logic                 dbz_q;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opb;

    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH:0]       msum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     diff;

    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_flag_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    // Magnitude of an operand; unsigned ops pass straight through.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic is_signed);
        logic signed [WIDTH-1:0] neg;
        neg = -x;
        if (is_signed && x[WIDTH-1])
            return neg;
        return x;
    endfunction

    // Restore signs: product negated on differing signs; quotient likewise,
    // remainder follows the dividend. 0x80000000 / -1 wraps naturally.
    function automatic logic [2*WIDTH-1:0] fix_sign(input logic is_div,
                                                    input logic sa,
                                                    input logic sb,
                                                    input logic [2*WIDTH-1:0] raw);
        logic signed [2*WIDTH-1:0] p;
        logic signed [WIDTH-1:0]   q;
        logic signed [WIDTH-1:0]   r;
        p = raw;
        q = raw[WIDTH-1:0];
        r = raw[2*WIDTH-1:WIDTH];
        if (is_div) begin
            if (sa ^ sb)
                q = -q;
            if (sa)
                r = -r;
            return {r, q};
        end
        if (sa ^ sb)
            p = -p;
        return p;
    endfunction

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        acc_nxt = acc;
        msum    = '0;
        rem_sh  = '0;
        diff    = '0;
        if (!op_q[1]) begin
            msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
            acc_nxt = {msum, acc[WIDTH-1:1]};
        end else begin
            rem_sh = acc[2*WIDTH-1:WIDTH-1];
            diff   = rem_sh[WIDTH-1:0] - opb;
            if (rem_sh >= {1'b0, opb})
                acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_flag_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q       <= bus.op;
                        cnt        <= '0;
                        busy_q     <= 1'b1;
                        dbz_flag_q <= 1'b0;
                        sign_a     <= bus.op[0] & bus.srcA[WIDTH-1];
                        sign_b     <= bus.op[0] & bus.srcB[WIDTH-1];
                        if (bus.op[1] && (bus.srcB == '0)) begin
                            // Divide by zero skips CALC; result is preloaded raw.
                            dbz_q <= 1'b1;
                            acc   <= {bus.srcA, {WIDTH{1'b1}}};
                            state <= FIN;
                        end else begin
                            dbz_q <= 1'b0;
                            state <= CALC;
                            if (bus.op[1]) begin
                                acc <= {{WIDTH{1'b0}}, magnitude(bus.srcA, bus.op[0])};
                                opb <= magnitude(bus.srcB, bus.op[0]);
                            end else begin
                                acc <= {{WIDTH{1'b0}}, magnitude(bus.srcB, bus.op[0])};
                                opb <= magnitude(bus.srcA, bus.op[0]);
                            end
                        end
                    end else begin
                        if (bus.hiWrite)
                            hi_q <= bus.writeData;
                        if (bus.loWrite)
                            lo_q <= bus.writeData;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 6'd1;
                    if (cnt == CNT_LAST)
                        state <= FIN;
                end
                FIN: begin
                    if (dbz_q) begin
                        {hi_q, lo_q} <= acc;
                        dbz_flag_q   <= 1'b1;
                    end else begin
                        {hi_q, lo_q} <= fix_sign(op_q[1], sign_a, sign_b, acc);
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.divByZero = dbz_flag_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
    logic clk;
    logic rst_n;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        dbz;
        logic [31:0] hi;
        logic [31:0] lo;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation, optionally injecting a start / MTHI while busy,
    // then wait for done and compare against the scoreboard head.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed,
                          input int ebusy, input bit b2b,
                          input int start_at, input int mthi_at);
        int  k;
        sb_t got;
        if (!b2b) begin
            @(negedge clk);
            check({tag, "/done_idle"}, 64'(bus.done), 64'd0);
        end
        bus.start     = 1'b1;
        bus.op        = op;
        bus.srcA      = a;
        bus.srcB      = b;
        bus.hiWrite   = 1'b1;
        bus.loWrite   = 1'b1;
        bus.writeData = $urandom;
        sb_q.push_back('{dbz: ed, hi: eh, lo: el});
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hiWrite = 1'b0;
        bus.loWrite = 1'b0;
        check({tag, "/busy_e0"}, 64'(bus.busy), 64'd1);
        check({tag, "/dbz_clr_e0"}, 64'(bus.divByZero), 64'd0);
        check({tag, "/hilo_start_prio"}, {bus.hi, bus.lo}, {model_hi, model_lo});
        k = 0;
        while (bus.busy && k < 200) begin
            bus.start = (k == start_at - 1);
            if (bus.start) begin
                bus.op   = 2'b10;
                bus.srcA = 32'd100;
                bus.srcB = 32'd7;
            end
            bus.hiWrite   = (k == mthi_at - 1);
            bus.writeData = 32'hDEADBEEF;
            @(negedge clk);
            k++;
            if (k == mthi_at)
                check({tag, "/mthi_ignored"}, 64'(bus.hi), 64'(model_hi));
        end
        bus.start   = 1'b0;
        bus.hiWrite = 1'b0;
        check({tag, "/busy_cycles"}, 64'(k), 64'(ebusy));
        check({tag, "/done"}, 64'(bus.done), 64'd1);
        check({tag, "/sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check({tag, "/hi"}, 64'(bus.hi), 64'(got.hi));
            check({tag, "/lo"}, 64'(bus.lo), 64'(got.lo));
            check({tag, "/divByZero"}, 64'(bus.divByZero), 64'(got.dbz));
            model_hi = got.hi;
            model_lo = got.lo;
        end
    endtask

    initial begin
        int done_seen;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.srcA      = '0;
        bus.srcB      = '0;
        bus.hiWrite   = 1'b0;
        bus.loWrite   = 1'b0;
        bus.writeData = '0;
        repeat (3) @(negedge clk);
        check("reset/hi", 64'(bus.hi), 64'd0);
        check("reset/lo", 64'(bus.lo), 64'd0);
        check("reset/busy", 64'(bus.busy), 64'd0);
        check("reset/done", 64'(bus.done), 64'd0);
        check("reset/divByZero", 64'(bus.divByZero), 64'd0);
        rst_n = 1'b1;

        // MTHI then MTLO in IDLE
        @(negedge clk);
        bus.hiWrite   = 1'b1;
        bus.writeData = 32'h12345678;
        @(negedge clk);
        bus.hiWrite   = 1'b0;
        bus.loWrite   = 1'b1;
        bus.writeData = 32'h9ABCDEF0;
        model_hi      = 32'h12345678;
        check("mthi", 64'(bus.hi), 64'(model_hi));
        @(negedge clk);
        bus.loWrite = 1'b0;
        model_lo    = 32'h9ABCDEF0;
        check("mtlo", 64'(bus.lo), 64'(model_lo));
        check("mtlo_hi_kept", 64'(bus.hi), 64'(model_hi));

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0, -1, -1);
        run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd7,
               32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0, -1, -1);
        run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0, -1, -1);
        run_op("div_wrap", 2'b11, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 1'b0, 33, 1'b0, -1, -1);
        run_op("divu_big", 2'b10, 32'hFFFFFFFF, 32'd10,
               32'd5, 32'h19999999, 1'b0, 33, 1'b0, -1, -1);
        run_op("divu_zero", 2'b10, 32'd5, 32'd0,
               32'd5, 32'hFFFFFFFF, 1'b1, 1, 1'b0, -1, -1);
        run_op("multu_b2b", 2'b00, 32'd2, 32'd3,
               32'd0, 32'd6, 1'b0, 33, 1'b1, -1, -1);
        run_op("multu_hazard", 2'b00, 32'd2, 32'd3,
               32'd0, 32'd6, 1'b0, 33, 1'b0, 10, 20);

        // Reset in the middle of a MULTU: result discarded, no done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.srcA  = 32'd9;
        bus.srcB  = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 14; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset/hi", 64'(bus.hi), 64'd0);
        check("midreset/lo", 64'(bus.lo), 64'd0);
        check("midreset/busy", 64'(bus.busy), 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done)
                done_seen++;
            @(negedge clk);
        end
        check("midreset/no_done", 64'(done_seen), 64'd0);
        check("midreset/lo_kept", 64'(bus.lo), 64'd0);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
